muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Sequential RV32M multiply/divide unit placed beside the single-cycle ALU in the EX stage.
- Accepts one operation at a time, iterates radix-2 over XLEN cycles, and returns a 32-bit result with a one-cycle done pulse.
- Busy is used by the hazard unit to stall IF/ID/EX.
- Flush from the hazard/branch logic aborts an in-flight operation.

Parameters:
- XLEN, 32, operand and result width; iteration count equals XLEN.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand; multiplicand or dividend.
- b  in  XLEN  rs2 operand; multiplier or divisor.
- flush  in  1  abort the current operation.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  XLEN  final value; held until the next accepted start.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0 at the edge: latch op, a, b; go to PREP.
  - Otherwise stay in IDLE.
- PREP (1 cycle):
  - Form operand magnitudes. Signed operands: MULH both, MULHSU a only, DIV/REM both. Record the result sign.
  - Divide by zero (b=0, op[2]=1): skip CALC, go to DONE. Results: DIV/DIVU = all ones; REM/REMU = a.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): skip CALC, go to DONE. Results: DIV = 0x80000000; REM = 0.
  - Otherwise: counter=0, go to CALC.
- CALC (exactly XLEN cycles; counter 0..XLEN-1):
  - Multiply: shift-add into a 2*XLEN product register.
  - Divide: restoring shift-subtract on a 2*XLEN remainder/quotient register.
  - Counter at XLEN-1 moves the state to FIX.
- FIX (1 cycle):
  - Apply two's-complement negation where the recorded sign requires it.
  - Select MUL = low word; MULH/MULHSU/MULHU = high word; DIV(U) = quotient; REM(U) = remainder.
  - Remainder takes the dividend's sign.
  - Write result, go to DONE.
- DONE (1 cycle): done=1, busy=1; next edge goes to IDLE with busy=0.
- Latency, normal path: start accepted at edge E0; done high in the cycle after edge E(XLEN+2), i.e. XLEN+3 cycles.
- Latency, special cases: done in the cycle after E1, i.e. 2 cycles.
- Back-to-back operations: start is ignored in DONE. The earliest next acceptance is the edge at which IDLE is entered plus one, because start is sampled only in IDLE.
- start while busy=1 is ignored; the latched operands are unaffected.
- flush:
  - Any non-IDLE state with flush=1 at an edge goes to IDLE, busy=0.
  - No done pulse for the aborted operation; result keeps its previous value.
  - start and flush in the same IDLE cycle: flush wins, nothing is accepted.
- rstn asserted mid-operation: immediate return to the reset values, regardless of clk.
- Width rules: all arithmetic is modulo 2^XLEN on the output. Internal magnitudes use XLEN+1 bits for the unsigned compare/subtract.

Test Plan:
- MUL: a=0xFFFFFFFF (-1), b=7, start pulse -> done exactly 35 cycles later, result=0xFFFFFFF9; MULHU of the same operands -> result=0x00000006; busy high throughout.
- MULH/MULHSU: a=0x80000000, b=0x80000000 -> MULH=0x40000000, MULHSU=0xC0000000, MULHU=0x40000000.
- DIV/REM signs:
  - a=-7 (0xFFFFFFF9), b=2 -> DIV=0xFFFFFFFD, REM=0xFFFFFFFF.
  - DIVU same operands -> 0x7FFFFFFC.
- Special cases, each with done 2 cycles after start:
  - DIV a=5, b=0 -> 0xFFFFFFFF.
  - REMU a=5, b=0 -> 5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Flush and ignored start:
  - DIVU a=100, b=3; assert flush 10 cycles after start -> busy=0 next cycle, no done, result keeps its old value.
  - A new start 1 cycle later -> result=33.
  - A start pulse during CALC is ignored.
- Reset: drop rstn asynchronously mid-CALC -> busy/done/result go to 0 without waiting for a clock edge. After release, MUL 3*4 -> 12 with normal latency.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit; radix-2, XLEN iterations.
// Ports: clk, rstn, start/op/a/b/flush in; busy/done/result out.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_bm;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_sa;
  logic              r_sb;
  logic [XLEN-1:0]   r_result;

  logic            w_is_div;
  logic            w_sa_en;
  logic            w_sb_en;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_ma;
  logic [XLEN-1:0] w_mb;
  logic            w_dz;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_spec_res;
  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [XLEN:0]   w_msum;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [2*XLEN-1:0] w_step;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_fix_res;
  logic            w_last;

  assign w_is_div = r_op[2];
  assign w_sa_en  = (r_op == 3'b001) | (r_op == 3'b010) |
                    (r_op == 3'b100) | (r_op == 3'b110);
  assign w_sb_en  = (r_op == 3'b001) | (r_op == 3'b100) |
                    (r_op == 3'b110);
  assign w_sa = w_sa_en & r_a[XLEN-1];
  assign w_sb = w_sb_en & r_b[XLEN-1];
  assign w_ma = w_sa ? (~r_a + 1'b1) : r_a;
  assign w_mb = w_sb ? (~r_b + 1'b1) : r_b;

  assign w_dz  = w_is_div && (r_b == '0);
  assign w_ovf = w_is_div && !r_op[0] &&
                 (r_a == MINV) && (r_b == '1);
  assign w_special = w_dz | w_ovf;

  always_comb begin
    w_spec_res = '0;
    if (w_dz) begin
      w_spec_res = r_op[1] ? r_a : '1;
    end else begin
      w_spec_res = r_op[1] ? '0 : MINV;
    end
  end

  assign w_hi = r_acc[2*XLEN-1:XLEN];
  assign w_lo = r_acc[XLEN-1:0];

  // Multiply: add multiplicand into the high half, shift right.
  assign w_msum = {1'b0, w_hi} +
                  (w_lo[0] ? {1'b0, r_bm} : '0);

  // Divide: shift remainder/quotient left, trial-subtract divisor.
  assign w_shift = {w_hi, w_lo[XLEN-1]};
  assign w_ge    = w_shift >= {1'b0, r_bm};
  assign w_diff  = w_shift - {1'b0, r_bm};

  always_comb begin
    w_step = r_acc;
    if (!w_is_div) begin
      w_step = {w_msum, w_lo[XLEN-1:1]};
    end else if (w_ge) begin
      w_step = {w_diff[XLEN-1:0], w_lo[XLEN-2:0], 1'b1};
    end else begin
      w_step = {w_shift[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
    end
  end

  assign w_prod = (r_sa ^ r_sb) ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = (r_sa ^ r_sb) ? (~w_lo + 1'b1) : w_lo;
  // Remainder follows the dividend's sign.
  assign w_rem  = r_sa ? (~w_hi + 1'b1) : w_hi;

  always_comb begin
    w_fix_res = '0;
    if (w_is_div) begin
      w_fix_res = r_op[1] ? w_rem : w_quo;
    end else if (r_op[1:0] == 2'b00) begin
      w_fix_res = w_prod[XLEN-1:0];
    end else begin
      w_fix_res = w_prod[2*XLEN-1:XLEN];
    end
  end

  assign w_last = (r_cnt == CW'(XLEN-1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start && !flush) w_next = S_PREP;
      end
      S_PREP: w_next = w_special ? S_DONE : S_CALC;
      S_CALC: if (w_last) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_bm     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
          end
        end
        S_PREP: begin
          if (!flush) begin
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_cnt <= '0;
            if (w_is_div) begin
              r_bm  <= w_mb;
              r_acc <= {{XLEN{1'b0}}, w_ma};
            end else begin
              r_bm  <= w_ma;
              r_acc <= {{XLEN{1'b0}}, w_mb};
            end
            if (w_special) r_result <= w_spec_res;
          end
        end
        S_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (!flush) r_result <= w_fix_res;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq.
// Scoreboard queue of expected results, one task per scenario.
module tb_muldiv_seq;

  localparam int XLEN  = 32;
  // Edges from the accepting edge to the first cycle with done=1.
  localparam int LAT_N = (XLEN + 3) - 1;
  localparam int LAT_S = 2 - 1;

  logic            clk;
  logic            rstn;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int n_checks;
  int n_errors;
  logic [XLEN-1:0] sb[$];
  logic [XLEN-1:0] last_res;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_op(input logic [2:0] o,
                       input logic [XLEN-1:0] x,
                       input logic [XLEN-1:0] y,
                       input logic [XLEN-1:0] e,
                       input int lat,
                       input int inj,
                       input string nm);
    int n;
    bit busy_ok;
    logic [XLEN-1:0] exp_v;
    sb.push_back(e);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
      start = (inj > 0 && n == inj);
      if (start) begin
        op = ~o;
        a = $urandom;
        b = $urandom;
      end
    end
    start = 1'b0;
    exp_v = sb.pop_front();
    n_checks++;
    if (n != lat) begin
      n_errors++;
      $display("FAIL %s latency: got %0d want %0d",
               nm, n, lat);
    end
    n_checks++;
    if (result !== exp_v) begin
      n_errors++;
      $display("FAIL %s result: got %h want %h",
               nm, result, exp_v);
    end
    n_checks++;
    if (!busy_ok || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL %s busy: got low want high", nm);
    end
    last_res = exp_v;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s pulse: got done=%b busy=%b want 0 0",
               nm, done, busy);
    end
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    n_checks++;
    if (result !== '0) begin
      n_errors++;
      $display("FAIL reset_result: got %h want 0", result);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    last_res = '0;
  endtask

  task automatic test_mul;
    do_op(3'b000, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9,
          LAT_N, 0, "mul");
    do_op(3'b011, 32'hFFFFFFFF, 32'd7, 32'h00000006,
          LAT_N, 0, "mulhu");
  endtask

  task automatic test_mulh;
    do_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000,
          LAT_N, 0, "mulh");
    do_op(3'b010, 32'h80000000, 32'h80000000, 32'hC0000000,
          LAT_N, 0, "mulhsu");
    do_op(3'b011, 32'h80000000, 32'h80000000, 32'h40000000,
          LAT_N, 0, "mulhu_min");
  endtask

  task automatic test_div;
    do_op(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD,
          LAT_N, 0, "div_neg");
    do_op(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF,
          LAT_N, 0, "rem_neg");
    do_op(3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC,
          LAT_N, 0, "divu");
  endtask

  task automatic test_special;
    do_op(3'b100, 32'd5, 32'd0, 32'hFFFFFFFF,
          LAT_S, 0, "div_by_zero");
    do_op(3'b111, 32'd5, 32'd0, 32'd5,
          LAT_S, 0, "remu_by_zero");
    do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,
          LAT_S, 0, "div_ovf");
    do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000,
          LAT_S, 0, "rem_ovf");
  endtask

  task automatic test_flush;
    bit saw_done;
    start = 1'b1;
    op = 3'b101;
    a = 32'd100;
    b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    saw_done = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_busy: got %b want 0", busy);
    end
    n_checks++;
    if (result !== last_res) begin
      n_errors++;
      $display("FAIL flush_result: got %h want %h",
               result, last_res);
    end
    repeat (3) begin
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (saw_done) begin
      n_errors++;
      $display("FAIL flush_no_done: got pulse want none");
    end
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL start_flush_idle: got busy=%b want 0",
               busy);
    end
    do_op(3'b101, 32'd100, 32'd3, 32'd33,
          LAT_N, 0, "divu_after_flush");
    do_op(3'b101, 32'd100, 32'd3, 32'd33,
          LAT_N, 5, "start_in_calc");
  endtask

  task automatic test_async_reset;
    start = 1'b1;
    op = 3'b000;
    a = 32'd9;
    b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset_ctl: got busy=%b done=%b want 0 0",
               busy, done);
    end
    n_checks++;
    if (result !== '0) begin
      n_errors++;
      $display("FAIL async_reset_result: got %h want 0",
               result);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    do_op(3'b000, 32'd3, 32'd4, 32'd12,
          LAT_N, 0, "mul_after_reset");
  endtask

  initial begin
    clk = 1'b0;
    rstn = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    n_checks = 0;
    n_errors = 0;
    last_res = '0;
    test_reset;
    test_mul;
    test_mulh;
    test_div;
    test_special;
    test_flush;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
